// File: rtl/axis_coincidence_pkg.sv
// Shared types and constants for the coincidence reader: FSM state encoding,
// drop counter width and the group-sum width helper.
package axis_coincidence_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REDUCE,
    SUM,
    DECIDE
  } state_t;

  localparam int DROP_WIDTH = 32;

  // Enough bits to hold a count of 0..groups fired groups.
  function automatic int sum_width(input int groups);
    return $clog2(groups + 1);
  endfunction

endpackage

// File: rtl/coincidence_group_reduce.sv
// Two-stage reduction of the collected hit mask: per-group OR (REDUCE stage)
// followed by a count of fired groups (SUM stage); both stages are enabled by the parent FSM.
module coincidence_group_reduce #(
  parameter int CHANNELS  = 64,
  parameter int GROUPS    = 4,
  parameter int SUM_WIDTH = 3
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 reduce_en,
  input  logic                 sum_en,
  input  logic [CHANNELS-1:0]  mask,
  output logic [GROUPS-1:0]    gmask,
  output logic [SUM_WIDTH-1:0] gsum
);

  localparam int GW = CHANNELS / GROUPS;

  logic [GROUPS-1:0]    gmask_next;
  logic [SUM_WIDTH-1:0] gsum_next;

  always_comb begin
    gmask_next = '0;
    for (int g = 0; g < GROUPS; g++) begin
      gmask_next[g] = |mask[g*GW +: GW];
    end
  end

  always_comb begin
    gsum_next = '0;
    for (int g = 0; g < GROUPS; g++) begin
      gsum_next = gsum_next + SUM_WIDTH'(gmask[g]);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      gmask <= '0;
      gsum  <= '0;
    end else begin
      if (reduce_en) gmask <= gmask_next;
      if (sum_en)    gsum  <= gsum_next;
    end
  end

endmodule

// File: rtl/axis_coincidence_reader.sv
// Multi-group coincidence detector with an AXI4-Stream event output and a saturating drop counter.
// Optional feature: define AXIS_COINCIDENCE_READER_TUSER_EN to export the fired-group mask on m_axis_tuser.
module axis_coincidence_reader #(
  parameter int CHANNELS   = 64,
  parameter int GROUPS     = 4,
  parameter int TIME_WIDTH = 64,
  parameter int CNTR_WIDTH = 8,
  parameter int SUM_WIDTH  = axis_coincidence_pkg::sum_width(GROUPS)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [CHANNELS-1:0]              din,
  input  logic [CNTR_WIDTH-1:0]            cfg_window,
  input  logic [SUM_WIDTH-1:0]             cfg_threshold,
  output logic [TIME_WIDTH+CHANNELS-1:0]   m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
  output logic [GROUPS-1:0]                m_axis_tuser,
`endif
  output logic [axis_coincidence_pkg::DROP_WIDTH-1:0] drop_count
);

  import axis_coincidence_pkg::*;

  state_t                state, state_next;
  logic [TIME_WIDTH-1:0] timer;
  logic [TIME_WIDTH-1:0] ts;
  logic [CHANNELS-1:0]   mask;
  logic [CNTR_WIDTH-1:0] cntr;
  logic [SUM_WIDTH-1:0]  gsum;
  logic                  reduce_en, sum_en, decide_en;
  logic                  slot_free, pass, load, drop;

  always_ff @(posedge aclk) begin
    if (!aresetn) timer <= '0;
    else          timer <= timer + TIME_WIDTH'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|din) state_next = COLLECT;
      COLLECT: if (cntr >= cfg_window) state_next = REDUCE;
      REDUCE:  state_next = SUM;
      SUM:     state_next = DECIDE;
      DECIDE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reduce_en = 1'b0;
    sum_en    = 1'b0;
    decide_en = 1'b0;
    case (state)
      REDUCE:  reduce_en = 1'b1;
      SUM:     sum_en    = 1'b1;
      DECIDE:  decide_en = 1'b1;
      default: ;
    endcase
  end

  // Hits are only accumulated in IDLE/COLLECT; later stages are dead time.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mask <= '0;
      cntr <= '0;
      ts   <= '0;
    end else begin
      case (state)
        IDLE: begin
          mask <= din;
          cntr <= '0;
          if (|din) ts <= timer;
        end
        COLLECT: begin
          mask <= mask | din;
          cntr <= cntr + CNTR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
  logic [GROUPS-1:0] gmask;
`else
  logic [GROUPS-1:0] gmask_unused;
`endif

  coincidence_group_reduce #(
    .CHANNELS (CHANNELS),
    .GROUPS   (GROUPS),
    .SUM_WIDTH(SUM_WIDTH)
  ) u_reduce (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .reduce_en(reduce_en),
    .sum_en   (sum_en),
    .mask     (mask),
`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
    .gmask    (gmask),
`else
    .gmask    (gmask_unused),
`endif
    .gsum     (gsum)
  );

  // A load may coincide with the handshake of the previous event.
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign pass      = gsum >= cfg_threshold;
  assign load      = decide_en && pass && slot_free;
  assign drop      = decide_en && pass && !slot_free;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {ts, mask};
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
  always_ff @(posedge aclk) begin
    if (!aresetn)  m_axis_tuser <= '0;
    else if (load) m_axis_tuser <= gmask;
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) drop_count <= '0;
    else if (drop && (drop_count != {DROP_WIDTH{1'b1}}))
      drop_count <= drop_count + DROP_WIDTH'(1);
  end

endmodule

// File: tb/tb_axis_coincidence_reader.sv
// Directed self-checking bench for axis_coincidence_reader (default parameters).
// Honours AXIS_COINCIDENCE_READER_TUSER_EN when the design is built with it.
module tb_axis_coincidence_reader;

  localparam int CHANNELS   = 64;
  localparam int GROUPS     = 4;
  localparam int TIME_WIDTH = 64;
  localparam int CNTR_WIDTH = 8;
  localparam int SUM_WIDTH  = 3;
  localparam int DW         = TIME_WIDTH + CHANNELS;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [CHANNELS-1:0]   din;
  logic [CNTR_WIDTH-1:0] cfg_window;
  logic [SUM_WIDTH-1:0]  cfg_threshold;
  logic [DW-1:0]         m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [31:0]           drop_count;
`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
  logic [GROUPS-1:0]     m_axis_tuser;
`endif

  int checks = 0;
  int errors = 0;

  // Reference timebase: counts edges since reset was last released.
  logic [TIME_WIDTH-1:0] tb_time;
  logic [TIME_WIDTH-1:0] t_a, t_b;
  logic                  saw_valid;

  axis_coincidence_reader dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .din          (din),
    .cfg_window   (cfg_window),
    .cfg_threshold(cfg_threshold),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
    .m_axis_tuser (m_axis_tuser),
`endif
    .drop_count   (drop_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (!aresetn) tb_time <= '0;
    else          tb_time <= tb_time + 64'd1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [CHANNELS-1:0] hits);
    din = hits;
  endtask

  task automatic check_output(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    din           = '0;
    cfg_window    = '0;
    cfg_threshold = '0;
    m_axis_tready = 1'b1;
    tick(3);
    check_output("reset_tvalid", DW'(m_axis_tvalid), '0);
    check_output("reset_tdata", m_axis_tdata, '0);
    check_output("reset_drop", DW'(drop_count), '0);
`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
    check_output("reset_tuser", DW'(m_axis_tuser), '0);
`endif
    aresetn = 1'b1;
    tick(2);

    // Single hit on channel 3, window 2: output at T+7 for one cycle.
    $display("[TB] single hit");
    cfg_window = 8'd2; cfg_threshold = 3'd1; m_axis_tready = 1'b1;
    apply_stimulus(64'h8); t_a = tb_time;
    tick(); apply_stimulus('0);
    tick(5);
    check_output("single_early", DW'(m_axis_tvalid), DW'(1'b0));
    tick();
    check_output("single_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("single_data", m_axis_tdata, {t_a, 64'h8});
    tick();
    check_output("single_one_cycle", DW'(m_axis_tvalid), DW'(1'b0));

    // Two groups fired (ch0 and ch40), threshold 2 passes.
    $display("[TB] two groups, threshold 2");
    cfg_window = 8'd4; cfg_threshold = 3'd2;
    apply_stimulus(64'h1); t_a = tb_time;
    tick(); apply_stimulus('0);
    tick(2); apply_stimulus(64'h0000_0100_0000_0000);
    tick(); apply_stimulus('0);
    tick(4);
    check_output("two_grp_early", DW'(m_axis_tvalid), DW'(1'b0));
    tick();
    check_output("two_grp_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("two_grp_data", m_axis_tdata, {t_a, 64'h0000_0100_0000_0001});
`ifdef AXIS_COINCIDENCE_READER_TUSER_EN
    check_output("two_grp_tuser", DW'(m_axis_tuser), DW'(4'b0101));
`endif
    tick();

    // Same hits with threshold 3: rejected, nothing emitted, nothing dropped.
    $display("[TB] two groups, threshold 3");
    cfg_threshold = 3'd3;
    saw_valid = 1'b0;
    apply_stimulus(64'h1);
    tick(); apply_stimulus('0); saw_valid |= m_axis_tvalid;
    tick(2); apply_stimulus(64'h0000_0100_0000_0000); saw_valid |= m_axis_tvalid;
    tick(); apply_stimulus('0);
    for (int i = 0; i < 8; i++) begin
      saw_valid |= m_axis_tvalid;
      tick();
    end
    check_output("thr3_no_valid", DW'(saw_valid), DW'(1'b0));
    check_output("thr3_no_drop", DW'(drop_count), '0);

    // Backpressure: first event held, second dropped, then one transfer.
    $display("[TB] backpressure drop");
    cfg_window = 8'd0; cfg_threshold = 3'd1; m_axis_tready = 1'b0;
    apply_stimulus(64'h20); t_a = tb_time;
    tick(); apply_stimulus('0);
    tick(4);
    check_output("bp_first_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("bp_first_data", m_axis_tdata, {t_a, 64'h20});
    apply_stimulus(64'h80);
    tick(); apply_stimulus('0);
    tick(4);
    check_output("bp_drop_count", DW'(drop_count), DW'(32'd1));
    check_output("bp_held_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("bp_held_data", m_axis_tdata, {t_a, 64'h20});
    m_axis_tready = 1'b1;
    tick();
    check_output("bp_transfer_once", DW'(m_axis_tvalid), DW'(1'b0));
    tick();
    check_output("bp_stays_low", DW'(m_axis_tvalid), DW'(1'b0));

    // DECIDE of event B coincides with the handshake of event A.
    $display("[TB] back-to-back load");
    m_axis_tready = 1'b0;
    apply_stimulus(64'h0000_0000_0001_0000); t_a = tb_time;
    tick(); apply_stimulus('0);
    tick(4);
    check_output("b2b_first_data", m_axis_tdata, {t_a, 64'h0000_0000_0001_0000});
    apply_stimulus(64'h8000_0000_0000_0000); t_b = tb_time;
    tick(); apply_stimulus('0);
    tick(3);
    m_axis_tready = 1'b1;
    tick();
    check_output("b2b_valid_kept", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("b2b_second_data", m_axis_tdata, {t_b, 64'h8000_0000_0000_0000});
    check_output("b2b_no_drop", DW'(drop_count), DW'(32'd1));
    tick();
    check_output("b2b_done", DW'(m_axis_tvalid), DW'(1'b0));

    // Dead-time hits are lost; a hit at T+W+5 starts a new event.
    $display("[TB] dead time");
    cfg_window = 8'd1;
    apply_stimulus(64'h2); t_a = tb_time;
    tick(); apply_stimulus('0);
    tick(2); apply_stimulus(64'h4);
    tick(); apply_stimulus(64'h200);
    tick(); apply_stimulus(64'h0010_0000);
    tick();
    check_output("dead_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("dead_data", m_axis_tdata, {t_a, 64'h2});
    apply_stimulus(64'h0000_0002_0000_0000); t_b = tb_time;
    tick(); apply_stimulus('0);
    check_output("dead_no_retrigger", DW'(m_axis_tvalid), DW'(1'b0));
    tick(5);
    check_output("retrig_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("retrig_data", m_axis_tdata, {t_b, 64'h0000_0002_0000_0000});
    tick();

    // Reset in COLLECT discards the event and clears counters and timer.
    $display("[TB] reset mid-event");
    cfg_window = 8'd5; cfg_threshold = 3'd0;
    apply_stimulus(64'h1);
    tick(); apply_stimulus('0);
    tick();
    aresetn = 1'b0;
    tick(2);
    check_output("rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    check_output("rst_drop", DW'(drop_count), '0);
    check_output("rst_tdata", m_axis_tdata, '0);
    cfg_window = 8'd0;
    aresetn = 1'b1;
    apply_stimulus(64'h1);
    tick(); apply_stimulus('0);
    tick(3);
    check_output("rst_no_stale", DW'(m_axis_tvalid), DW'(1'b0));
    tick();
    check_output("rst_timer_zero_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check_output("rst_timer_zero_data", m_axis_tdata, {64'd0, 64'h1});
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
